multi_port_fifo: RTL and testbench

//  Multi-port FIFO with PUSH_CH write lanes and POP_CH read lanes of DATA_WIDTH each.

---
 rtl/multi_port_fifo_if.sv | 32 +++
 rtl/multi_port_fifo.sv | 145 ++++++++++++++
 tb/tb_multi_port_fifo.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/multi_port_fifo_if.sv
// Bus bundle for multi_port_fifo.
// The master side is the producer/consumer (fetch/decode pushing, issue popping).
// The slave side is the FIFO itself.
interface multi_port_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int PUSH_CH    = 4,
  parameter int POP_CH     = 2
);
  logic                           flush;
  logic [PUSH_CH-1:0]             push_mask;
  logic [PUSH_CH*DATA_WIDTH-1:0]  data_push;
  logic [$clog2(POP_CH+1)-1:0]    pop_num;
  logic [POP_CH*DATA_WIDTH-1:0]   data_pop;
  logic [POP_CH-1:0]              pop_valid;
  logic [$clog2(DEPTH+1)-1:0]     count;
  logic [$clog2(DEPTH+1)-1:0]     free_cnt;
  logic                           full;
  logic                           empty;
  logic                           overflow;
  logic                           underflow;

  modport master (
    output flush, push_mask, data_push, pop_num,
    input  data_pop, pop_valid, count, free_cnt, full, empty, overflow, underflow
  );

  modport slave (
    input  flush, push_mask, data_push, pop_num,
    output data_pop, pop_valid, count, free_cnt, full, empty, overflow, underflow
  );
endinterface

// File: rtl/multi_port_fifo.sv
// multi_port_fifo: instruction buffer between fetch/decode and issue.
// Up to PUSH_CH sparse write lanes per cycle are compacted into consecutive
// entries; the oldest POP_CH entries are always shown on the read window.
// Pushes are all-or-nothing against the free space at the start of the cycle.
// Optional feature macro: MULTI_PORT_FIFO_BYPASS_EN
//   defined   -> window lanes beyond the stored count are filled from this
//                cycle's accepted push data and may be consumed directly.
//   undefined -> registered-only window, one-cycle push-to-pop latency.
// DEPTH must be a power of two so the pointers wrap by truncation.
module multi_port_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int PUSH_CH    = 4,
  parameter int POP_CH     = 2
) (
  input logic               clk,
  input logic               rst,
  multi_port_fifo_if.slave  bus
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PIW = (PUSH_CH > 1) ? $clog2(PUSH_CH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic          overflow_q;
  logic          underflow_q;

  logic                  flush;
  logic [DATA_WIDTH-1:0] comp_data [PUSH_CH];
  logic [CW-1:0]         n_push;
  logic [CW-1:0]         n_push_acc;
  logic [CW-1:0]         n_push_byp;
  logic [CW-1:0]         free_cnt;
  logic [CW-1:0]         avail;
  logic [CW-1:0]         pop_req;
  logic [CW-1:0]         n_pop;
  logic [CW-1:0]         byp_used;
  logic [CW-1:0]         count_next;
  logic                  push_ok;
  logic                  pop_under;

  logic [POP_CH*DATA_WIDTH-1:0] win_data;
  logic [POP_CH-1:0]            win_valid;

  assign flush = bus.flush;

  // Compact the set push lanes, in lane order, into ranks 0..n_push-1.
  always_comb begin
    n_push = '0;
    for (int i = 0; i < PUSH_CH; i++) begin
      comp_data[i] = '0;
    end
    for (int i = 0; i < PUSH_CH; i++) begin
      if (bus.push_mask[i]) begin
        comp_data[PIW'(n_push)] = bus.data_push[i*DATA_WIDTH +: DATA_WIDTH];
        n_push = n_push + CW'(1);
      end
    end
  end

  // Space is judged on the current count; same-cycle pops never make room.
  assign free_cnt   = CW'(DEPTH) - count;
  assign push_ok    = (n_push <= free_cnt);
  assign n_push_acc = push_ok ? n_push : '0;
  assign pop_req    = CW'(bus.pop_num);

`ifdef MULTI_PORT_FIFO_BYPASS_EN
  // Accepted push data is visible to the window in the same cycle unless flushed.
  assign n_push_byp = flush ? '0 : n_push_acc;
`else
  assign n_push_byp = '0;
`endif

  // Entries the window can offer this cycle: stored plus any bypassed ones.
  assign avail      = count + n_push_byp;
  assign pop_under  = (pop_req > avail);
  assign n_pop      = pop_under ? avail : pop_req;
  // Bypassed entries consumed this cycle; these ranks are never stored.
  assign byp_used   = (n_pop > count) ? (n_pop - count) : '0;
  assign count_next = count + n_push_acc - n_pop;

  // Pointer, occupancy and sticky error flags; flush only clears the queue state.
  always_ff @(posedge clk) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(n_pop);
      tail  <= tail + AW'(n_push_acc);
      count <= count_next;
      if (!push_ok) begin
        overflow_q <= 1'b1;
      end
      if (pop_under) begin
        underflow_q <= 1'b1;
      end
    end
  end

  // Store accepted push ranks at tail+rank, skipping ranks already consumed by bypass.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int k = 0; k < PUSH_CH; k++) begin
        if ((CW'(k) >= byp_used) && (CW'(k) < n_push_acc)) begin
          mem[tail + AW'(k)] <= comp_data[k];
        end
      end
    end
  end

  // Read window: lane j shows entry head+j, or a bypassed push rank beyond the stored count.
  always_comb begin
    win_data  = '0;
    win_valid = '0;
    for (int j = 0; j < POP_CH; j++) begin
      win_data[j*DATA_WIDTH +: DATA_WIDTH] = mem[head + AW'(j)];
      win_valid[j] = (CW'(j) < avail);
      if ((CW'(j) >= count) && (CW'(j) < avail)) begin
        win_data[j*DATA_WIDTH +: DATA_WIDTH] = comp_data[PIW'(CW'(j) - count)];
      end
    end
  end

  assign bus.data_pop  = win_data;
  assign bus.pop_valid = win_valid;
  assign bus.count     = count;
  assign bus.free_cnt  = free_cnt;
  assign bus.full      = (count == CW'(DEPTH));
  assign bus.empty     = (count == '0);
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_multi_port_fifo.sv
// Directed bench for multi_port_fifo with DATA_WIDTH=8, DEPTH=8, PUSH_CH=4, POP_CH=2.
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
module tb_multi_port_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int PUSH_CH = 4;
  localparam int POP_CH = 2;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  multi_port_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PUSH_CH(PUSH_CH), .POP_CH(POP_CH)) bus ();

  multi_port_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PUSH_CH(PUSH_CH), .POP_CH(POP_CH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] mask, input logic [31:0] data,
                       input logic [1:0] popn, input logic fl);
    bus.push_mask = mask;
    bus.data_push = data;
    bus.pop_num   = popn;
    bus.flush     = fl;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(4'b0000, 32'h0, 2'd0, 1'b0);

    // reset state
    tick();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_free", 32'(bus.free_cnt), 32'd8);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_valid", 32'(bus.pop_valid), 32'b00);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_unf", 32'(bus.underflow), 32'd0);
    rst = 1'b0;

    // sparse push compaction: lanes 1 and 3
    drive(4'b1010, 32'h33EE11DD, 2'd0, 1'b0);
    tick();
    chk("cmp_data", 32'(bus.data_pop), 32'h3311);
    chk("cmp_valid", 32'(bus.pop_valid), 32'b11);
    chk("cmp_count", 32'(bus.count), 32'd2);

    // full-width push
    drive(4'b1111, 32'h23222120, 2'd0, 1'b0);
    tick();
    chk("p4_count", 32'(bus.count), 32'd6);
    chk("p4_data", 32'(bus.data_pop), 32'h3311);

    // 4 lanes with only 2 free: rejected
    drive(4'b1111, 32'hFFFFFFFF, 2'd0, 1'b0);
    tick();
    chk("rej_count", 32'(bus.count), 32'd6);
    chk("rej_ovf", 32'(bus.overflow), 32'd1);
    chk("rej_full", 32'(bus.full), 32'd0);

    // exactly free_cnt lanes: accepted, becomes full
    drive(4'b0101, 32'h00250024, 2'd0, 1'b0);
    tick();
    chk("full_count", 32'(bus.count), 32'd8);
    chk("full_flag", 32'(bus.full), 32'd1);
    chk("full_free", 32'(bus.free_cnt), 32'd0);
    chk("full_empty", 32'(bus.empty), 32'd0);
    chk("full_data", 32'(bus.data_pop), 32'h3311);

    // wrap: pop 2 per cycle, refill with 2-lane pushes
    drive(4'b0000, 32'h0, 2'd2, 1'b0);
    tick();
    chk("wa_count", 32'(bus.count), 32'd6);
    chk("wa_data", 32'(bus.data_pop), 32'h2120);

    drive(4'b0011, 32'h0000A1A0, 2'd2, 1'b0);
    tick();
    chk("wb_count", 32'(bus.count), 32'd6);
    chk("wb_data", 32'(bus.data_pop), 32'h2322);

    drive(4'b1100, 32'hA3A20000, 2'd2, 1'b0);
    tick();
    chk("wc_count", 32'(bus.count), 32'd6);
    chk("wc_data", 32'(bus.data_pop), 32'h2524);

    drive(4'b1001, 32'hA50000A4, 2'd2, 1'b0);
    tick();
    chk("wd_count", 32'(bus.count), 32'd6);
    chk("wd_data", 32'(bus.data_pop), 32'hA1A0);

    drive(4'b0110, 32'h00A7A600, 2'd2, 1'b0);
    tick();
    chk("we_count", 32'(bus.count), 32'd6);
    chk("we_data", 32'(bus.data_pop), 32'hA3A2);

    drive(4'b0000, 32'h0, 2'd2, 1'b0);
    tick();
    chk("wf_count", 32'(bus.count), 32'd4);
    chk("wf_data", 32'(bus.data_pop), 32'hA5A4);

    tick();
    chk("wg_count", 32'(bus.count), 32'd2);
    chk("wg_data", 32'(bus.data_pop), 32'hA7A6);

    drive(4'b0000, 32'h0, 2'd1, 1'b0);
    tick();
    chk("wh_count", 32'(bus.count), 32'd1);
    chk("wh_valid", 32'(bus.pop_valid), 32'b01);
    chk("wh_data0", 32'(bus.data_pop[7:0]), 32'hA7);
    chk("wh_unf", 32'(bus.underflow), 32'd0);

    // over-pop: count 1, pop 2
    drive(4'b0000, 32'h0, 2'd2, 1'b0);
    tick();
    chk("unf_count", 32'(bus.count), 32'd0);
    chk("unf_empty", 32'(bus.empty), 32'd1);
    chk("unf_flag", 32'(bus.underflow), 32'd1);
    chk("unf_valid", 32'(bus.pop_valid), 32'b00);

    // push with flush: flush wins, sticky flags stay
    drive(4'b1111, 32'h44332211, 2'd0, 1'b1);
    tick();
    chk("fl_count", 32'(bus.count), 32'd0);
    chk("fl_empty", 32'(bus.empty), 32'd1);
    chk("fl_valid", 32'(bus.pop_valid), 32'b00);
    chk("fl_ovf", 32'(bus.overflow), 32'd1);
    chk("fl_unf", 32'(bus.underflow), 32'd1);
    drive(4'b0000, 32'h0, 2'd0, 1'b0);
    tick();
    chk("fl_count2", 32'(bus.count), 32'd0);

    // reset mid-stream discards contents and clears sticky flags
    drive(4'b0011, 32'h00007776, 2'd0, 1'b0);
    tick();
    chk("mr_count", 32'(bus.count), 32'd2);
    drive(4'b1111, 32'h11111111, 2'd0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_rcount", 32'(bus.count), 32'd0);
    chk("mr_rfree", 32'(bus.free_cnt), 32'd8);
    chk("mr_rovf", 32'(bus.overflow), 32'd0);
    chk("mr_runf", 32'(bus.underflow), 32'd0);
    drive(4'b0001, 32'h00000099, 2'd0, 1'b0);
    tick();
    chk("mr_count1", 32'(bus.count), 32'd1);
    chk("mr_valid1", 32'(bus.pop_valid), 32'b01);
    chk("mr_data1", 32'(bus.data_pop[7:0]), 32'h99);

    // drain, then push two lanes and pop one on an empty FIFO
    drive(4'b0000, 32'h0, 2'd1, 1'b0);
    tick();
    chk("bp_pre_empty", 32'(bus.empty), 32'd1);
    drive(4'b0011, 32'h00005544, 2'd1, 1'b0);
    #1;
`ifdef MULTI_PORT_FIFO_BYPASS_EN
    chk("bp_same_valid", 32'(bus.pop_valid), 32'b11);
    chk("bp_same_data", 32'(bus.data_pop), 32'h5544);
    tick();
    chk("bp_count", 32'(bus.count), 32'd1);
    chk("bp_valid", 32'(bus.pop_valid), 32'b01);
    chk("bp_data0", 32'(bus.data_pop[7:0]), 32'h55);
    chk("bp_unf", 32'(bus.underflow), 32'd0);
`else
    chk("nb_same_valid", 32'(bus.pop_valid), 32'b00);
    tick();
    chk("nb_count", 32'(bus.count), 32'd2);
    chk("nb_valid", 32'(bus.pop_valid), 32'b11);
    chk("nb_data", 32'(bus.data_pop), 32'h5544);
    chk("nb_unf", 32'(bus.underflow), 32'd1);
`endif

    drive(4'b0000, 32'h0, 2'd0, 1'b0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
